soc_decerr_slave: RTL and testbench
===================================

SOC_DECERR_SLAVE -- requirements
Module: soc_decerr_slave

Interface
REQ-001 SHALL have parameter AxiIdWidth, default 7 (IdWidthSlave), the width of the AXI ID fields.
REQ-002 SHALL have parameter AxiAddrWidth, default 64, the width of the AXI address fields.
REQ-003 SHALL have parameter AxiDataWidth, default 64, the width of the R data field.
REQ-004 SHALL have parameter RespData, default 64'hBADC_AB1E_BADC_AB1E, the value driven on every R beat.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports aw_valid_i in 1, aw_ready_o out 1, aw_id_i in AxiIdWidth, aw_addr_i in AxiAddrWidth, aw_len_i in 8, forming the write-address channel.
REQ-008 SHALL have ports w_valid_i in 1, w_ready_o out 1, w_last_i in 1, forming the write-data channel (data and strobe are not used).
REQ-009 SHALL have ports b_valid_o out 1, b_ready_i in 1, b_id_o out AxiIdWidth, b_resp_o out 2, forming the write-response channel.
REQ-010 SHALL have ports ar_valid_i in 1, ar_ready_o out 1, ar_id_i in AxiIdWidth, ar_addr_i in AxiAddrWidth, ar_len_i in 8, forming the read-address channel.
REQ-011 SHALL have ports r_valid_o out 1, r_ready_i in 1, r_id_o out AxiIdWidth, r_data_o out AxiDataWidth, r_resp_o out 2, r_last_o out 1, forming the read-data channel.
REQ-012 SHALL have port err_cnt_o, output, 16, the saturating count of accepted erroneous transactions.
REQ-013 SHALL have port err_addr_o, output, AxiAddrWidth, the address of the most recently accepted transaction.

Function
REQ-014 SHALL be the default (no-rule-match) slave of the SoC crossbar, answering every transaction with DECERR (2'b11) on b_resp_o and r_resp_o.
REQ-015 SHALL run the write path as an FSM with states W_IDLE, W_DATA and W_RESP.
REQ-016 SHALL in W_IDLE assert aw_ready_o; on aw_valid_i&&aw_ready_o it SHALL latch aw_id_i, then go to W_DATA.
REQ-017 SHALL in W_DATA assert w_ready_o and sink beats; on a handshake with w_last_i=1 it SHALL go to W_RESP, and aw_len_i SHALL be ignored (the W beat count is defined by w_last_i).
REQ-018 SHALL in W_RESP assert b_valid_o with b_id_o equal to the latched ID, hold it stable until b_ready_i, then go to W_IDLE, with aw_ready_o low throughout.
REQ-019 SHALL run the read path independently as an FSM with states R_IDLE and R_DATA.
REQ-020 SHALL in R_IDLE assert ar_ready_o; on handshake it SHALL latch ar_id_i, load beat counter = ar_len_i, then go to R_DATA.
REQ-021 SHALL in R_DATA assert r_valid_o with r_data_o=RespData, r_resp_o=DECERR and r_id_o equal to the latched ID.
REQ-022 SHALL drive r_last_o=1 in R_DATA exactly when the beat counter is 0.
REQ-023 SHALL decrement the beat counter on each r_valid_o&&r_ready_i; the final handshake SHALL return the FSM to R_IDLE, so ar_len_i+1 beats are returned in total (256 for len=255, with no wrap).
REQ-024 SHALL hold all R outputs stable while r_valid_o=1 and r_ready_i=0.
REQ-025 SHALL respond with first-beat latency of one cycle: B valid the cycle after the W last handshake, R valid the cycle after the AR handshake.
REQ-026 SHALL increment err_cnt_o by 1 per AW handshake and by 1 per AR handshake, and by 2 on simultaneous handshakes.
REQ-027 SHALL saturate err_cnt_o at 16'hFFFF; an increment of 2 from 16'hFFFE SHALL yield 16'hFFFF.
REQ-028 SHALL update err_addr_o on each AW or AR handshake; on simultaneous handshakes ar_addr_i SHALL win.
REQ-029 SHALL allow a W beat arriving before or in the same cycle as AW to wait, since w_ready_o is low outside W_DATA.

Reset
REQ-030 SHALL, with rst_ni low (asynchronously), force both FSMs to idle, the counters to 0, and err_cnt_o=0 and err_addr_o=0.
REQ-031 SHALL drive, during reset, aw_ready_o=0, ar_ready_o=0, w_ready_o=0, b_valid_o=0, r_valid_o=0 and r_last_o=0, and all ID/resp/data outputs to 0.
REQ-032 SHALL, if reset asserts mid-burst, abandon the in-flight transaction with no completion after release, and assert aw_ready_o/ar_ready_o in the first cycle after rst_ni rises.

Verification
REQ-033 SHALL be verified with: AW id=5 addr=0x5000_0000, then 4 W beats (last on 4th), b_ready=1 -> one B with id=5, resp=2'b11, one cycle after W last; err_cnt=1; err_addr=0x5000_0000.
REQ-034 SHALL be verified with: AR id=3 len=7, r_ready=1 -> 8 R beats with data=RespData, resp=DECERR, id=3, and r_last only on beat 8; ar_ready low until beat 8 completes.
REQ-035 SHALL be verified with: AR len=2 with r_ready toggling 1/0 -> R outputs held stable during stalls; exactly 3 beats.
REQ-036 SHALL be verified with: AW and AR handshaking in the same cycle, addresses 0x100/0x200 -> err_cnt +2; err_addr=0x200; B and R complete independently.
REQ-037 SHALL be verified with: err_cnt preloaded to 0xFFFE via traffic and simultaneous AW+AR -> err_cnt=0xFFFF, then stays 0xFFFF.
REQ-038 SHALL be verified with: rst_ni pulsed low during beat 2 of an 8-beat read -> r_valid drops immediately; after release, no further R beats and ar_ready=1.

Source files
------------

// File: rtl/soc_decerr_slave.sv
// -----------------------------------------------------------------------------
// soc_decerr_slave
//
// Default slave of the SoC crossbar. Any transaction that matched no address
// rule lands here and is answered with DECERR. Write and read paths are
// independent FSMs; a small error log records how many transactions arrived
// (saturating) and the address of the most recent one.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   aw_*                   write-address channel (aw_len_i is ignored)
//   w_valid_i/w_ready_o    write-data channel; the burst ends on w_last_i
//   b_*                    write-response channel, always DECERR
//   ar_*                   read-address channel
//   r_*                    read-data channel, ar_len_i+1 beats of RespData
//   err_cnt_o              saturating count of accepted AW + AR handshakes
//   err_addr_o             address of the most recently accepted request
//   dbg_w_state            write FSM state (0 idle, 1 data, 2 resp)
//   dbg_r_state            read FSM state (0 idle, 1 data)
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and
// ready are both high. This slave never drops a valid it has raised and
// keeps every payload output stable until the matching ready arrives.
// -----------------------------------------------------------------------------
module soc_decerr_slave #(
  parameter int unsigned AxiIdWidth   = 7,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter logic [AxiDataWidth-1:0] RespData = AxiDataWidth'(64'hBADC_AB1E_BADC_AB1E)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // write address
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [AxiIdWidth-1:0]   aw_id_i,
  input  logic [AxiAddrWidth-1:0] aw_addr_i,
  input  logic [7:0]              aw_len_i,
  // write data
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic                    w_last_i,
  // write response
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [AxiIdWidth-1:0]   b_id_o,
  output logic [1:0]              b_resp_o,
  // read address
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [7:0]              ar_len_i,
  // read data
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  // error log
  output logic [15:0]             err_cnt_o,
  output logic [AxiAddrWidth-1:0] err_addr_o,
  // FSM state visibility
  output logic [1:0]              dbg_w_state,
  output logic                    dbg_r_state
);

  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [AxiIdWidth-1:0] w_id_q;
  logic [AxiIdWidth-1:0] r_id_q;
  logic [7:0]            r_cnt_q, r_cnt_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_ready_raw, ar_ready_raw;

  // The burst length of a write is defined by w_last_i alone.
  logic aw_len_unused;
  assign aw_len_unused = ^aw_len_i;

  // Address readies are gated with the reset pin itself so they read 0 while
  // reset is held and rise in the very first cycle after release, without
  // waiting for a clock edge to update a flop.
  assign aw_ready_o = aw_ready_raw & rst_ni;
  assign ar_ready_o = ar_ready_raw & rst_ni;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i  & w_ready_o;
  assign b_hs  = b_valid_o  & b_ready_i;
  assign ar_hs = ar_valid_i & ar_ready_o;
  assign r_hs  = r_valid_o  & r_ready_i;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        w_id_q <= aw_id_i;
      end
    end
  end

  always_comb begin
    w_state_d    = w_state_q;
    aw_ready_raw = 1'b0;
    w_ready_o    = 1'b0;
    b_valid_o    = 1'b0;
    b_id_o       = '0;
    b_resp_o     = 2'b00;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready_raw = 1'b1;
        if (aw_hs) begin
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        // Beats that show up before the AW handshake simply wait here.
        w_ready_o = 1'b1;
        if (w_hs && w_last_i) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        b_id_o    = w_id_q;
        b_resp_o  = RespDecErr;
        if (b_ready_i) begin
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      if (ar_hs) begin
        r_id_q <= ar_id_i;
      end
    end
  end

  always_comb begin
    r_state_d    = r_state_q;
    r_cnt_d      = r_cnt_q;
    ar_ready_raw = 1'b0;
    r_valid_o    = 1'b0;
    r_id_o       = '0;
    r_data_o     = '0;
    r_resp_o     = 2'b00;
    r_last_o     = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready_raw = 1'b1;
        if (ar_hs) begin
          r_cnt_d   = ar_len_i;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        r_id_o    = r_id_q;
        r_data_o  = RespData;
        r_resp_o  = RespDecErr;
        // The counter holds the number of beats still to come after this one,
        // so the last beat is the one presented with a zero count. Leaving on
        // that handshake instead of decrementing avoids a wrap at len=255.
        r_last_o  = (r_cnt_q == 8'd0);
        if (r_hs) begin
          if (r_cnt_q == 8'd0) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q - 8'd1;
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Error log
  // ---------------------------------------------------------------------------
  logic [16:0] err_sum;

  // One extra bit catches both FFFF+1 and FFFE+2 as overflow.
  assign err_sum = {1'b0, err_cnt_o} + {15'd0, aw_hs} + {15'd0, ar_hs};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o  <= '0;
      err_addr_o <= '0;
    end else begin
      err_cnt_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      // On a simultaneous handshake the read address is the one recorded.
      if (ar_hs) begin
        err_addr_o <= ar_addr_i;
      end else if (aw_hs) begin
        err_addr_o <= aw_addr_i;
      end
    end
  end

  assign dbg_w_state = w_state_q;
  assign dbg_r_state = r_state_q;

endmodule

// File: tb/tb_soc_decerr_slave.sv
// -----------------------------------------------------------------------------
// tb_soc_decerr_slave
//
// Drives directed and randomized AXI traffic into soc_decerr_slave and
// compares every cycle against a transaction-level model: pending B
// responses and R beats are kept as queues of expected items, and the error
// log is recomputed with saturating integer arithmetic.
// -----------------------------------------------------------------------------
module tb_soc_decerr_slave;

  localparam logic [63:0] RESP_DATA = 64'hBADC_AB1E_BADC_AB1E;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        aw_valid_i = 0, aw_ready_o;
  logic [6:0]  aw_id_i = 0;
  logic [63:0] aw_addr_i = 0;
  logic [7:0]  aw_len_i = 0;
  logic        w_valid_i = 0, w_ready_o, w_last_i = 0;
  logic        b_valid_o, b_ready_i = 0;
  logic [6:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i = 0, ar_ready_o;
  logic [6:0]  ar_id_i = 0;
  logic [63:0] ar_addr_i = 0;
  logic [7:0]  ar_len_i = 0;
  logic        r_valid_o, r_ready_i = 0;
  logic [6:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic [15:0] err_cnt_o;
  logic [63:0] err_addr_o;
  logic [1:0]  dbg_w_state;
  logic        dbg_r_state;

  soc_decerr_slave dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o),
    .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model / scoreboard
  // ---------------------------------------------------------------------------
  bit          mon_en = 0;
  bit          m_w_open;          // AW accepted, W burst not yet finished
  logic [6:0]  m_w_id;
  logic [6:0]  exp_b_q[$];        // B responses owed
  logic [7:0]  exp_r_q[$];        // R beats owed: {last, id}
  logic [15:0] m_cnt;
  logic [63:0] m_addr;
  int          b_done = 0;
  int          r_done = 0;

  bit          stall_prev = 0;
  logic [6:0]  snap_id;
  logic [63:0] snap_data;
  logic [1:0]  snap_resp;
  logic        snap_last;

  task automatic model_clear();
    m_w_open = 0;
    m_w_id   = '0;
    exp_b_q.delete();
    exp_r_q.delete();
    m_cnt    = '0;
    m_addr   = '0;
  endtask

  bit         aw_hs, w_hs, b_hs, ar_hs, r_hs, exp_aw_rdy, exp_ar_rdy;
  logic [7:0] head;
  int         total;

  always @(negedge clk) begin
    if (mon_en && rst_ni) begin
      exp_aw_rdy = !m_w_open && (exp_b_q.size() == 0);
      exp_ar_rdy = (exp_r_q.size() == 0);
      check("aw_ready", aw_ready_o, exp_aw_rdy);
      check("w_ready", w_ready_o, m_w_open);
      check("b_valid", b_valid_o, exp_b_q.size() != 0);
      check("ar_ready", ar_ready_o, exp_ar_rdy);
      check("r_valid", r_valid_o, exp_r_q.size() != 0);
      check("err_cnt", err_cnt_o, m_cnt);
      check("err_addr", err_addr_o, m_addr);
      if (exp_b_q.size() != 0) begin
        check("b_id", b_id_o, exp_b_q[0]);
        check("b_resp", b_resp_o, 2'b11);
      end
      if (exp_r_q.size() != 0) begin
        head = exp_r_q[0];
        check("r_id", r_id_o, head[6:0]);
        check("r_last", r_last_o, head[7]);
        check("r_data", r_data_o, RESP_DATA);
        check("r_resp", r_resp_o, 2'b11);
      end else begin
        check("r_last_idle", r_last_o, 1'b0);
      end
      if (stall_prev) begin
        check("r_hold_id", r_id_o, snap_id);
        check("r_hold_data", r_data_o, snap_data);
        check("r_hold_resp", r_resp_o, snap_resp);
        check("r_hold_last", r_last_o, snap_last);
      end
      stall_prev = r_valid_o && !r_ready_i;
      snap_id = r_id_o; snap_data = r_data_o; snap_resp = r_resp_o; snap_last = r_last_o;

      // Transfers that will happen on the coming rising edge.
      aw_hs = aw_valid_i && exp_aw_rdy;
      w_hs  = w_valid_i && m_w_open;
      b_hs  = b_ready_i && (exp_b_q.size() != 0);
      ar_hs = ar_valid_i && exp_ar_rdy;
      r_hs  = r_ready_i && (exp_r_q.size() != 0);

      if (b_hs) begin
        void'(exp_b_q.pop_front());
        b_done++;
      end
      if (aw_hs) begin
        m_w_open = 1;
        m_w_id   = aw_id_i;
      end
      if (w_hs && w_last_i) begin
        m_w_open = 0;
        exp_b_q.push_back(m_w_id);
      end
      if (r_hs) begin
        void'(exp_r_q.pop_front());
        r_done++;
      end
      if (ar_hs) begin
        for (int i = 0; i <= int'(ar_len_i); i++) begin
          exp_r_q.push_back({(i == int'(ar_len_i)), ar_id_i});
        end
      end
      total = int'(m_cnt) + int'(aw_hs) + int'(ar_hs);
      m_cnt = (total > 65535) ? 16'hFFFF : 16'(total);
      if (aw_hs) m_addr = aw_addr_i;
      if (ar_hs) m_addr = ar_addr_i;
    end else begin
      stall_prev = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  int ready_mode = 0;  // 0: always ready, 1: r_ready toggles, 2: random

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: begin r_ready_i = 1; b_ready_i = 1; end
        1: begin r_ready_i = ~r_ready_i; b_ready_i = 1; end
        default: begin
          r_ready_i = 1'($urandom_range(0, 1));
          b_ready_i = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_aw(input logic [6:0] id, input logic [63:0] addr);
    bit ok = 0;
    aw_id_i = id; aw_addr_i = addr; aw_len_i = 8'($urandom_range(0, 255));
    aw_valid_i = 1;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk);
      ok = aw_ready_o;
    end
    check("aw_wait", ok, 1'b1);
    @(posedge clk);
    #1;
    aw_valid_i = 0;
  endtask

  task automatic send_w(input int beats);
    for (int b = 0; b < beats; b++) begin
      bit ok = 0;
      w_valid_i = 0;
      idle_cycles($urandom_range(0, 2));
      w_valid_i = 1;
      w_last_i  = (b == beats - 1);
      for (int n = 0; n < 5000 && !ok; n++) begin
        @(negedge clk);
        ok = w_ready_o;
      end
      check("w_wait", ok, 1'b1);
      @(posedge clk);
      #1;
    end
    w_valid_i = 0;
    w_last_i  = 0;
  endtask

  task automatic send_ar(input logic [6:0] id, input logic [63:0] addr, input logic [7:0] len);
    bit ok = 0;
    ar_id_i = id; ar_addr_i = addr; ar_len_i = len;
    ar_valid_i = 1;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk);
      ok = ar_ready_o;
    end
    check("ar_wait", ok, 1'b1);
    @(posedge clk);
    #1;
    ar_valid_i = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(posedge clk);
      #1;
      ok = !m_w_open && (exp_b_q.size() == 0) && (exp_r_q.size() == 0);
    end
    check("idle_wait", ok, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int r_base, b_base, guard;

  initial begin
    model_clear();

    // Reset values
    idle_cycles(3);
    check("rst_aw_ready", aw_ready_o, 0);
    check("rst_ar_ready", ar_ready_o, 0);
    check("rst_w_ready", w_ready_o, 0);
    check("rst_b_valid", b_valid_o, 0);
    check("rst_r_valid", r_valid_o, 0);
    check("rst_r_last", r_last_o, 0);
    check("rst_b_id", b_id_o, 0);
    check("rst_b_resp", b_resp_o, 0);
    check("rst_r_id", r_id_o, 0);
    check("rst_r_data", r_data_o, 0);
    check("rst_r_resp", r_resp_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    check("rst_err_addr", err_addr_o, 0);
    @(posedge clk);
    #2;
    rst_ni = 1;
    #1;
    check("rel_aw_ready", aw_ready_o, 1);
    check("rel_ar_ready", ar_ready_o, 1);
    mon_en = 1;
    idle_cycles(1);

    // Single write: W beats are offered before AW and must wait
    b_base = b_done;
    fork
      send_aw(7'd5, 64'h5000_0000);
      send_w(4);
    join
    wait_idle();
    check("wr_b_count", b_done - b_base, 1);
    check("wr_err_cnt", err_cnt_o, 1);
    check("wr_err_addr", err_addr_o, 64'h5000_0000);

    // 8-beat read, always ready
    r_base = r_done;
    send_ar(7'd3, 64'h3000, 8'd7);
    wait_idle();
    check("rd8_beats", r_done - r_base, 8);

    // 3-beat read with r_ready toggling
    ready_mode = 1;
    r_base = r_done;
    send_ar(7'd9, 64'h9000, 8'd2);
    wait_idle();
    check("rd3_beats", r_done - r_base, 3);
    ready_mode = 0;
    idle_cycles(1);

    // Simultaneous AW and AR
    fork
      send_aw(7'd1, 64'h100);
      send_w(2);
      send_ar(7'd2, 64'h200, 8'd1);
    join
    wait_idle();
    check("sim_err_cnt", err_cnt_o, 5);
    check("sim_err_addr", err_addr_o, 64'h200);

    // Random concurrent traffic with random back-pressure
    ready_mode = 2;
    for (int it = 0; it < 30; it++) begin
      fork
        begin
          if ($urandom_range(0, 3) != 0) begin
            idle_cycles($urandom_range(0, 3));
            fork
              send_aw(7'($urandom), {$urandom, $urandom});
              send_w($urandom_range(1, 6));
            join
          end
        end
        begin
          if ($urandom_range(0, 3) != 0) begin
            idle_cycles($urandom_range(0, 3));
            send_ar(7'($urandom), {$urandom, $urandom}, 8'($urandom_range(0, 15)));
          end
        end
      join
      wait_idle();
    end

    // Longest burst: 256 beats, no wrap
    ready_mode = 0;
    r_base = r_done;
    send_ar(7'd77, 64'hFFFF_0000, 8'd255);
    wait_idle();
    check("rd256_beats", r_done - r_base, 256);

    // Drive the error counter up to 0xFFFE with back-to-back traffic
    aw_addr_i = 64'hA; ar_addr_i = 64'hB; ar_len_i = 0;
    w_last_i = 1; w_valid_i = 1; aw_valid_i = 1; ar_valid_i = 1;
    guard = 0;
    while (m_cnt < 16'hFFF0 && guard < 90000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    aw_valid_i = 0; ar_valid_i = 0;
    idle_cycles(4);
    w_valid_i = 0; w_last_i = 0;
    wait_idle();
    guard = 0;
    while (m_cnt < 16'hFFFE && guard < 100) begin
      send_ar(7'd0, 64'hC, 8'd0);
      wait_idle();
      guard++;
    end
    check("pre_sat_cnt", err_cnt_o, 16'hFFFE);
    fork
      send_aw(7'd11, 64'h100);
      send_w(1);
      send_ar(7'd12, 64'h200, 8'd0);
    join
    wait_idle();
    check("sat_cnt", err_cnt_o, 16'hFFFF);
    send_ar(7'd13, 64'h300, 8'd0);
    wait_idle();
    check("sat_hold_cnt", err_cnt_o, 16'hFFFF);

    // Reset during beat 2 of an 8-beat read
    r_base = r_done;
    send_ar(7'd21, 64'h2100, 8'd7);
    @(posedge clk);
    #3;
    mon_en = 0;
    rst_ni = 0;
    #1;
    check("mid_rst_r_valid", r_valid_o, 0);
    check("mid_rst_r_last", r_last_o, 0);
    check("mid_rst_ar_ready", ar_ready_o, 0);
    check("mid_rst_aw_ready", aw_ready_o, 0);
    check("mid_rst_err_cnt", err_cnt_o, 0);
    check("mid_rst_err_addr", err_addr_o, 0);
    model_clear();
    idle_cycles(2);
    #1;
    rst_ni = 1;
    #1;
    check("post_rst_ar_ready", ar_ready_o, 1);
    check("post_rst_aw_ready", aw_ready_o, 1);
    check("post_rst_r_valid", r_valid_o, 0);
    mon_en = 1;
    idle_cycles(20);
    check("rst_beats", r_done - r_base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
